axi_rd_slave: RTL and testbench
===============================

AXI_RD_SLAVE -- requirements
Module: axi_rd_slave

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 64'h8000_0000, byte address of memory word 0.
REQ-002 SHALL have parameter MEM_AW, default 16, log2 of the number of 64-bit memory words.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have ports ARID in 4, ARADDR in 64, ARLEN in 8, ARSIZE in 3, ARBURST in 2, ARVALID in 1, ARREADY out 1: the AXI4 read-address channel.
REQ-006 SHALL have ports RID out 4, RDATA out 64, RRESP out 2, RLAST out 1, RVALID out 1, RREADY in 1: the AXI4 read-data channel.
REQ-007 SHALL have ports mem_en out 1, mem_addr out MEM_AW, mem_rdata in 64: a synchronous-read memory port with 1-cycle latency.

Function
REQ-008 SHALL accept one transaction at a time and run states IDLE, FETCH, DATA.
REQ-009 SHALL drive ARREADY=1 only in IDLE.
REQ-010 SHALL, on an AR handshake, latch ARID/ARADDR/ARLEN/ARSIZE/ARBURST, load beat counter=ARLEN, and go to FETCH.
REQ-011 SHALL, in FETCH, pulse mem_en for exactly one cycle if the current beat is OKAY, drive mem_addr=(addr-ADDR_BASE)>>3, and go to DATA next cycle.
REQ-012 SHALL raise RVALID in the first DATA cycle with RDATA=mem_rdata (or 0 on an error beat), RID=latched ID, and RLAST=(counter==0).
REQ-013 SHALL hold RID/RDATA/RRESP/RLAST stable while RVALID=1 and RREADY=0.
REQ-014 SHALL, on an R handshake with RLAST=0, decrement the counter, advance the address, and return to FETCH.
REQ-015 SHALL, on an R handshake with RLAST=1, drop RVALID and return to IDLE.
REQ-016 Latency: AR handshake at cycle T, mem_en at T+1, RVALID at T+2; peak throughput one beat per 2 cycles.
REQ-017 SHALL always return exactly ARLEN+1 beats, including on error.
REQ-018 SHALL advance the address as follows:
- FIXED (00): address constant.
- INCR (01): next = (addr aligned down to 2^ARSIZE) + 2^ARSIZE, 64-bit wrap-around, no 4KB check.
- WRAP (10): boundary = (ARLEN+1)<<ARSIZE; next = (addr & ~(boundary-1)) | ((addr+2^ARSIZE) & (boundary-1)).
REQ-019 SHALL return RRESP=SLVERR (10) on every beat and perform no mem access if: ARBURST=11; ARSIZE>3; WRAP with ARLEN not in {1,3,7,15}; or WRAP with ARADDR unaligned to 2^ARSIZE.
REQ-020 SHALL return RRESP=DECERR (11) and RDATA=0, with no mem access, for any beat whose address lies outside [ADDR_BASE, ADDR_BASE + 2^MEM_AW*8); other beats of the same burst SHALL return OKAY.
REQ-021 SHALL return the full aligned 64-bit word on RDATA; the master selects byte lanes for narrow transfers.
REQ-022 SHALL ignore ARVALID outside IDLE. An AR handshake and a last-beat R handshake never coincide, because ARREADY=0 in DATA.

Reset
REQ-023 SHALL, while rst=1, asynchronously force: state=IDLE; ARREADY=0; RVALID=0; RLAST=0; RID=0; RDATA=0; RRESP=0; mem_en=0; counter and address = 0.
REQ-024 SHALL abandon any in-flight burst on reset, with no further beats, and present ARREADY=1 on the first clk edge after rst falls.

Structure
REQ-025 SHALL take the AXBURST_FIXED/INCR/WRAP, XRESP_OKAY/EXOKAY/SLVERR/DECERR and AXSIZE_1..8 constants, plus the state encoding, from a shared axi_pkg package also used by axi_interface.
REQ-026 SHALL place the next-address computation (REQ-018) in a combinational sub-module axi_addr_gen, to be reused by a future write slave.

Verification
REQ-027 Test 1: ARADDR=0x8000_0000, ARLEN=0, ARSIZE=2, INCR, RREADY=1 -> RVALID at T+2, RDATA=mem word 0, RRESP=00, RLAST=1, RID=0.
REQ-028 Test 2: ARADDR=0x8000_0008, ARLEN=3, ARSIZE=3, INCR, RREADY toggling 1/0 -> 4 beats for words 1..4, outputs stable during stalls, RLAST on beat 4 only.
REQ-029 Test 3: ARADDR=0x8000_0018, ARLEN=3, ARSIZE=3, WRAP -> word sequence 3,0,1,2; ARADDR=0x8000_0004, WRAP, ARSIZE=3 -> 4 SLVERR beats, mem_en never asserted.
REQ-030 Test 4: INCR burst ARLEN=1 starting at the last word (ADDR_BASE + 2^MEM_AW*8 - 8) -> beat 1 OKAY, beat 2 DECERR with RDATA=0.
REQ-031 Test 5: assert rst during beat 2 of an ARLEN=7 burst -> RVALID=0 immediately, ARREADY=1 after release, and a new burst completes correctly.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 constants, field types and the read-slave state encoding.
package axi_pkg;

    typedef logic [1:0] axi_burst_t;
    typedef logic [1:0] axi_resp_t;

    localparam axi_burst_t AXBURST_FIXED = 2'b00;
    localparam axi_burst_t AXBURST_INCR  = 2'b01;
    localparam axi_burst_t AXBURST_WRAP  = 2'b10;
    localparam axi_burst_t AXBURST_RSVD  = 2'b11;

    localparam axi_resp_t XRESP_OKAY   = 2'b00;
    localparam axi_resp_t XRESP_EXOKAY = 2'b01;
    localparam axi_resp_t XRESP_SLVERR = 2'b10;
    localparam axi_resp_t XRESP_DECERR = 2'b11;

    localparam logic [2:0] AXSIZE_1 = 3'd0;
    localparam logic [2:0] AXSIZE_2 = 3'd1;
    localparam logic [2:0] AXSIZE_4 = 3'd2;
    localparam logic [2:0] AXSIZE_8 = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DATA
    } rd_state_t;

    // A burst this slave cannot serve: reserved burst type, beats wider than
    // the 64-bit bus, or a WRAP with an illegal length or unaligned start.
    function automatic logic burst_illegal(input logic [63:0] addr, input logic [7:0] len,
                                           input logic [2:0] size, input axi_burst_t burst);
        logic [63:0] lane_mask;
        logic        bad;
        lane_mask = (64'd1 << size) - 64'd1;
        bad = (burst == AXBURST_RSVD) || (size > AXSIZE_8);
        if (burst == AXBURST_WRAP) begin
            bad = bad || !(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((addr & lane_mask) != 64'd0);
        end
        return bad;
    endfunction

endpackage

// File: rtl/axi_interface.sv
// AXI4 read-address and read-data channels bundled for master and slave use.
interface axi_interface;
    import axi_pkg::*;

    logic [3:0]  ARID;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    axi_burst_t  ARBURST;
    logic        ARVALID;
    logic        ARREADY;

    logic [3:0]  RID;
    logic [63:0] RDATA;
    axi_resp_t   RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

endinterface

// File: rtl/axi_addr_gen.sv
// Next-beat address for FIXED, INCR and WRAP bursts; purely combinational.
module axi_addr_gen
    import axi_pkg::*;
(
    input  logic [63:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  axi_burst_t  burst,
    output logic [63:0] next_addr
);

    logic [63:0] step;
    logic [63:0] wrap_mask;

    // Step by one beat, folding back inside the wrap window for WRAP bursts.
    always_comb begin
        // NOTE: every output gets a value before the case so no path can infer a latch.
        step      = 64'd1 << size;
        wrap_mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
        next_addr = addr;
        case (burst)
            AXBURST_INCR: next_addr = (addr & ~(step - 64'd1)) + step;
            AXBURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:      next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_rd_slave.sv
// Single-outstanding AXI4 read slave in front of a 1-cycle synchronous-read memory.
module axi_rd_slave
    import axi_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
    parameter int          MEM_AW    = 16
) (
    input  logic              clk,
    input  logic              rst,
    axi_interface.slave       axi,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [63:0]       mem_rdata
);

    localparam logic [63:0] MEM_BYTES = 64'd8 << MEM_AW;

    rd_state_t   state;
    logic [3:0]  id_q;
    logic [63:0] addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    axi_burst_t  burst_q;
    logic [7:0]  cnt_q;
    logic        err_q;
    logic        dec_q;
    logic        first_q;
    logic [63:0] rdata_q;

    logic [63:0] next_addr;
    logic [63:0] fetch_addr;
    logic [63:0] fetch_off;
    logic        fetch_err;
    logic        fetch_dec;
    logic        fetch_ok;
    logic [63:0] rdata_out;

    axi_addr_gen u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Classify the beat about to be fetched: a new burst from AR, or the next beat.
    always_comb begin
        fetch_addr = (state == ST_IDLE) ? axi.ARADDR : next_addr;
        fetch_err  = (state == ST_IDLE)
                   ? burst_illegal(axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST) : err_q;
        fetch_off  = fetch_addr - ADDR_BASE;
        fetch_dec  = (fetch_addr < ADDR_BASE) || (fetch_off >= MEM_BYTES);
        fetch_ok   = !fetch_err && !fetch_dec;
    end

    // Memory data arrives in the first DATA cycle; it is held in rdata_q during stalls.
    always_comb begin
        rdata_out = rdata_q;
        if (first_q) begin
            rdata_out = (axi.RRESP == XRESP_OKAY) ? mem_rdata : 64'd0;
        end
    end

    assign axi.RDATA = rdata_out;

    // Burst sequencer: IDLE accepts AR, FETCH issues the memory read, DATA presents the beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= AXBURST_FIXED;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            dec_q       <= 1'b0;
            first_q     <= 1'b0;
            rdata_q     <= '0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            axi.ARREADY <= 1'b0;
            axi.RVALID  <= 1'b0;
            axi.RLAST   <= 1'b0;
            axi.RID     <= '0;
            axi.RRESP   <= XRESP_OKAY;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            mem_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    axi.ARREADY <= 1'b1;
                    if (axi.ARVALID && axi.ARREADY) begin
                        id_q        <= axi.ARID;
                        addr_q      <= axi.ARADDR;
                        len_q       <= axi.ARLEN;
                        size_q      <= axi.ARSIZE;
                        burst_q     <= axi.ARBURST;
                        cnt_q       <= axi.ARLEN;
                        err_q       <= fetch_err;
                        dec_q       <= fetch_dec;
                        mem_en      <= fetch_ok;
                        mem_addr    <= MEM_AW'(fetch_off >> 3);
                        axi.ARREADY <= 1'b0;
                        state       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    axi.RVALID <= 1'b1;
                    axi.RID    <= id_q;
                    axi.RLAST  <= (cnt_q == 8'd0);
                    axi.RRESP  <= err_q ? XRESP_SLVERR : (dec_q ? XRESP_DECERR : XRESP_OKAY);
                    first_q    <= 1'b1;
                    state      <= ST_DATA;
                end
                ST_DATA: begin
                    first_q <= 1'b0;
                    if (first_q) begin
                        rdata_q <= rdata_out;
                    end
                    if (axi.RREADY) begin
                        axi.RVALID <= 1'b0;
                        if (axi.RLAST) begin
                            axi.ARREADY <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            cnt_q    <= cnt_q - 8'd1;
                            addr_q   <= next_addr;
                            dec_q    <= fetch_dec;
                            mem_en   <= fetch_ok;
                            mem_addr <= MEM_AW'(fetch_off >> 3);
                            state    <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_slave.sv
// Self-checking bench for axi_rd_slave: vector table plus scoreboard, and a reset-abort sequence.
module tb_axi_rd_slave;
    import axi_pkg::*;

    localparam int          MEM_AW = 8;
    localparam logic [63:0] BASE   = 64'h8000_0000;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [3:0]       id;
        logic [63:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             toggle;
        logic [3:0][7:0]  words;
        logic [3:0][1:0]  resps;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_interface axi ();

    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [63:0]       mem_rdata = '0;
    logic [63:0]       mem [0:(1<<MEM_AW)-1];

    logic rready_q    = 1'b1;
    logic toggle_mode = 1'b0;
    logic hold_ready  = 1'b0;
    logic mon_en      = 1'b0;
    assign axi.RREADY = rready_q;

    axi_rd_slave #(.ADDR_BASE(BASE), .MEM_AW(MEM_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .axi       (axi),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    beats_seen   = 0;
    int    mem_en_cnt   = 0;
    int    first_rv_cyc = -1;
    int    first_me_cyc = -1;
    logic  stall_prev   = 1'b0;
    beat_t stall_val;
    beat_t exp_q[$];
    vec_t  vecs[12];

    function automatic logic [63:0] word_val(input int i);
        return {32'hC0DE_0000 | 32'(i), (32'(i) * 32'h0101_0101) ^ 32'h5A5A_5A5A};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input logic tog,
                                input int w0, input int w1, input int w2, input int w3,
                                input logic [1:0] r0, input logic [1:0] r1,
                                input logic [1:0] r2, input logic [1:0] r3);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.toggle = tog;
        v.words[0] = 8'(w0); v.words[1] = 8'(w1); v.words[2] = 8'(w2); v.words[3] = 8'(w3);
        v.resps[0] = r0; v.resps[1] = r1; v.resps[2] = r2; v.resps[3] = r3;
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (hold_ready)       rready_q = 1'b0;
        else if (toggle_mode) rready_q = ~rready_q;
        else                  rready_q = 1'b1;
    end

    // Monitor: counts mem_en, checks stall stability, pops the scoreboard on each R handshake.
    initial forever begin
        beat_t cur;
        beat_t e;
        @(negedge clk);
        if (mon_en) begin
            if (mem_en) begin
                mem_en_cnt++;
                if (first_me_cyc < 0) first_me_cyc = cyc;
            end
            if (axi.RVALID) begin
                if (first_rv_cyc < 0) first_rv_cyc = cyc;
                cur = {axi.RID, axi.RDATA, axi.RRESP, axi.RLAST};
                if (stall_prev) check("stall_hold", 128'(cur), 128'(stall_val));
                if (axi.RREADY) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 128'(exp_q.size()), 128'(1));
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 128'(axi.RDATA), 128'(e.data));
                        check("beat_id_resp_last", 128'({axi.RID, axi.RRESP, axi.RLAST}),
                              128'({e.id, e.resp, e.last}));
                    end
                    beats_seen++;
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    stall_val  = cur;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic issue_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, output int t_hs);
        logic seen;
        seen = 1'b0;
        t_hs = -100;
        @(posedge clk);
        #1;
        axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = len;
        axi.ARSIZE = size; axi.ARBURST = burst; axi.ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi.ARREADY) begin
                seen = 1'b1;
                t_hs = cyc;
                break;
            end
        end
        check("ar_handshake", 128'(seen), 128'(1));
        @(posedge clk);
        #1;
        axi.ARVALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && axi.ARREADY) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 128'(done), 128'(1));
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n_ok;
        int t_hs;
        n_ok = 0;
        for (int k = 0; k <= int'(v.len); k++) begin
            beat_t b;
            b.id   = v.id;
            b.resp = v.resps[k];
            b.data = (v.resps[k] == XRESP_OKAY) ? word_val(int'(v.words[k])) : 64'd0;
            b.last = (k == int'(v.len));
            exp_q.push_back(b);
            if (v.resps[k] == XRESP_OKAY) n_ok++;
        end
        toggle_mode  = v.toggle;
        mem_en_cnt   = 0;
        first_rv_cyc = -1;
        first_me_cyc = -1;
        issue_ar(v.id, v.addr, v.len, v.size, v.burst, t_hs);
        wait_idle($sformatf("v%0d_complete", idx));
        check($sformatf("v%0d_rvalid_latency", idx), 128'(first_rv_cyc - t_hs), 128'(2));
        if (v.resps[0] == XRESP_OKAY) begin
            check($sformatf("v%0d_mem_en_latency", idx), 128'(first_me_cyc - t_hs), 128'(1));
        end
        check($sformatf("v%0d_mem_en_count", idx), 128'(mem_en_cnt), 128'(n_ok));
        toggle_mode = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int   b0;
        int   t_hs;
        logic got;

        axi.ARVALID = 1'b0; axi.ARID = '0; axi.ARADDR = '0;
        axi.ARLEN = '0; axi.ARSIZE = '0; axi.ARBURST = '0;
        for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = word_val(i);

        vecs[0]  = mk(4'd0,  BASE,           8'd0, 3'd2, AXBURST_INCR,  1'b0, 0, 0, 0, 0,
                      XRESP_OKAY, XRESP_OKAY, XRESP_OKAY, XRESP_OKAY);
        vecs[1]  = mk(4'd5,  BASE + 64'h8,   8'd3, 3'd3, AXBURST_INCR,  1'b1, 1, 2, 3, 4,
                      XRESP_OKAY, XRESP_OKAY, XRESP_OKAY, XRESP_OKAY);
        vecs[2]  = mk(4'd3,  BASE + 64'h18,  8'd3, 3'd3, AXBURST_WRAP,  1'b0, 3, 0, 1, 2,
                      XRESP_OKAY, XRESP_OKAY, XRESP_OKAY, XRESP_OKAY);
        vecs[3]  = mk(4'd7,  BASE + 64'h4,   8'd3, 3'd3, AXBURST_WRAP,  1'b0, 0, 0, 0, 0,
                      XRESP_SLVERR, XRESP_SLVERR, XRESP_SLVERR, XRESP_SLVERR);
        vecs[4]  = mk(4'd9,  BASE + 64'h7F8, 8'd1, 3'd3, AXBURST_INCR,  1'b0, 255, 0, 0, 0,
                      XRESP_OKAY, XRESP_DECERR, XRESP_OKAY, XRESP_OKAY);
        vecs[5]  = mk(4'd2,  BASE + 64'h10,  8'd2, 3'd3, AXBURST_FIXED, 1'b1, 2, 2, 2, 0,
                      XRESP_OKAY, XRESP_OKAY, XRESP_OKAY, XRESP_OKAY);
        vecs[6]  = mk(4'd4,  BASE + 64'h4,   8'd2, 3'd2, AXBURST_INCR,  1'b0, 0, 1, 1, 0,
                      XRESP_OKAY, XRESP_OKAY, XRESP_OKAY, XRESP_OKAY);
        vecs[7]  = mk(4'd6,  BASE,           8'd1, 3'd3, AXBURST_RSVD,  1'b0, 0, 0, 0, 0,
                      XRESP_SLVERR, XRESP_SLVERR, XRESP_OKAY, XRESP_OKAY);
        vecs[8]  = mk(4'd8,  BASE,           8'd2, 3'd3, AXBURST_WRAP,  1'b0, 0, 0, 0, 0,
                      XRESP_SLVERR, XRESP_SLVERR, XRESP_SLVERR, XRESP_OKAY);
        vecs[9]  = mk(4'd10, BASE - 64'h8,   8'd1, 3'd3, AXBURST_INCR,  1'b1, 0, 0, 0, 0,
                      XRESP_DECERR, XRESP_OKAY, XRESP_OKAY, XRESP_OKAY);
        vecs[10] = mk(4'd11, BASE,           8'd0, 3'd4, AXBURST_INCR,  1'b0, 0, 0, 0, 0,
                      XRESP_SLVERR, XRESP_OKAY, XRESP_OKAY, XRESP_OKAY);
        vecs[11] = mk(4'd12, BASE + 64'h14,  8'd3, 3'd2, AXBURST_WRAP,  1'b1, 2, 3, 3, 2,
                      XRESP_OKAY, XRESP_OKAY, XRESP_OKAY, XRESP_OKAY);

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #2;
        check("rst_arready", 128'(axi.ARREADY), 128'(0));
        check("rst_rvalid",  128'(axi.RVALID),  128'(0));
        check("rst_rdata",   128'(axi.RDATA),   128'(0));
        check("rst_rid_resp_last", 128'({axi.RID, axi.RRESP, axi.RLAST}), 128'(0));
        check("rst_mem_en",  128'(mem_en),      128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arready_after_rst", 128'(axi.ARREADY), 128'(1));
        mon_en = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset in the middle of beat 2 of an 8-beat burst.
        for (int k = 0; k < 8; k++) begin
            beat_t b;
            b.id = 4'd1; b.data = word_val(k); b.resp = XRESP_OKAY; b.last = (k == 7);
            exp_q.push_back(b);
        end
        b0 = beats_seen;
        issue_ar(4'd1, BASE, 8'd7, 3'd3, AXBURST_INCR, t_hs);
        for (int i = 0; i < 50 && beats_seen == b0; i++) @(negedge clk);
        hold_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (axi.RVALID) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_beat2_present", 128'(got), 128'(1));
        check("abort_beats_before", 128'(beats_seen - b0), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        mon_en = 1'b0;
        exp_q.delete();
        check("abort_rvalid",  128'(axi.RVALID),  128'(0));
        check("abort_arready", 128'(axi.ARREADY), 128'(0));
        check("abort_rid_resp_last", 128'({axi.RID, axi.RRESP, axi.RLAST}), 128'(0));
        check("abort_rdata",   128'(axi.RDATA),   128'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_hold_rvalid", 128'({axi.RVALID, mem_en}), 128'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        hold_ready = 1'b0;
        stall_prev = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check("abort_arready_release", 128'(axi.ARREADY), 128'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_stale_beat", 128'(axi.RVALID), 128'(0));
        end
        run_vec(vecs[0], 100);
        run_vec(vecs[1], 101);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
